// File: rtl/bf_alu_pipe.sv
// Single-slot execute unit for the threadbrain tape machine: cell arithmetic, pointer
// moves, run-length branches, byte I/O handshakes and HALT, with a one-cycle writeback forward.
module bf_alu_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PTR_W  = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ins_in,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [DATA_W-1:0] val_in,
  output logic [PTR_W-1:0]  ptr_select,
  output logic [DATA_W-1:0] val_out,
  output logic              wb_en,
  output logic [PTR_W-1:0]  ptr_wb,
  output logic [ADDR_W-1:0] branch_val,
  output logic              branch_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              halted
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_PLUS  = 4'h1,
    OP_MINUS = 4'h2,
    OP_INC   = 4'h3,
    OP_DEC   = 4'h4,
    OP_BRZ   = 4'h5,
    OP_BRNZ  = 4'h6,
    OP_OUT   = 4'h7,
    OP_IN    = 4'h8,
    OP_HALT  = 4'hF
  } op_e;

  logic [15:0]       r_ins;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_wptr;
  logic [DATA_W-1:0] r_fwd_val;
  logic              r_fwd_vld;
  logic              r_halted;

  op_e               w_op;
  logic [11:0]       w_imm;
  logic [DATA_W-1:0] w_opv;
  logic [PTR_W-1:0]  w_ptr_next;
  logic              w_stall;
  logic              w_halt_op;

  assign w_op  = op_e'(r_ins[15:12]);
  assign w_imm = (r_ins[11:0] == 12'd0) ? 12'd1 : r_ins[11:0];

  // Memory lags a write by one cycle, so a same-cell read right after a write takes the forward.
  assign w_opv = (r_fwd_vld && (r_ptr == r_wptr)) ? r_fwd_val : val_in;

  always_comb begin
    w_ptr_next = r_ptr;
    val_out    = '0;
    wb_en      = 1'b0;
    branch_en  = 1'b0;
    branch_val = '0;
    out_data   = '0;
    out_valid  = 1'b0;
    in_ready   = 1'b0;
    w_stall    = 1'b0;
    w_halt_op  = 1'b0;
    case (w_op)
      OP_PLUS: begin
        val_out = w_opv + DATA_W'(w_imm);
        wb_en   = 1'b1;
      end
      OP_MINUS: begin
        val_out = w_opv - DATA_W'(w_imm);
        wb_en   = 1'b1;
      end
      OP_INC: w_ptr_next = r_ptr + PTR_W'(w_imm);
      OP_DEC: w_ptr_next = r_ptr - PTR_W'(w_imm);
      OP_BRZ: begin
        if (w_opv == '0) begin
          branch_en  = 1'b1;
          branch_val = r_ins[ADDR_W-1:0];
        end
      end
      OP_BRNZ: begin
        if (w_opv != '0) begin
          branch_en  = 1'b1;
          branch_val = r_ins[ADDR_W-1:0];
        end
      end
      OP_OUT: begin
        out_data  = w_opv;
        out_valid = 1'b1;
        w_stall   = !out_ready;
      end
      OP_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          val_out = in_data;
          wb_en   = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      OP_HALT: w_halt_op = 1'b1;
      default: ;
    endcase
  end

  assign ins_ready  = !r_halted && !w_halt_op && !w_stall && !branch_en;
  assign ptr_select = w_ptr_next;
  assign ptr_wb     = r_ptr;
  assign halted     = r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins     <= '0;
      r_ptr     <= '0;
      r_wptr    <= '0;
      r_fwd_val <= '0;
      r_fwd_vld <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_next;
      r_wptr    <= r_ptr;
      r_fwd_val <= val_out;
      r_fwd_vld <= wb_en;
      if (w_halt_op) r_halted <= 1'b1;
      if (!w_stall) r_ins <= (ins_valid && ins_ready) ? ins_in : '0;
    end
  end

endmodule

// File: tb/tb_bf_alu_pipe.sv
// Directed bench for bf_alu_pipe: inputs change on the falling edge, outputs are checked 1ns later.
module tb_bf_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic [15:0] ins_in;
  logic        ins_valid;
  logic        ins_ready;
  logic [15:0] val_in;
  logic [15:0] ptr_select;
  logic [15:0] val_out;
  logic        wb_en;
  logic [15:0] ptr_wb;
  logic [11:0] branch_val;
  logic        branch_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        halted;

  int unsigned n_checks;
  int unsigned n_errors;

  bf_alu_pipe #(.DATA_W(16), .PTR_W(16), .ADDR_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_in     (ins_in),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .val_in     (val_in),
    .ptr_select (ptr_select),
    .val_out    (val_out),
    .wb_en      (wb_en),
    .ptr_wb     (ptr_wb),
    .branch_val (branch_val),
    .branch_en  (branch_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic present(input logic [15:0] ins);
    ins_in    = ins;
    ins_valid = 1'b1;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    ins_in    = '0;
    ins_valid = 1'b0;
    val_in    = '0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_wb_en", wb_en, 0);
    check("rst_branch_en", branch_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ins_ready", ins_ready, 1);
    check("rst_ptr_select", ptr_select, 0);
    check("rst_ptr_wb", ptr_wb, 0);
    check("rst_halted", halted, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;

    // Arithmetic and immediate handling
    do_reset();
    present(16'h1005); val_in = 16'h0003;
    nxt(); ins_valid = 1'b0;
    check("plus5_val", val_out, 16'h0008);
    check("plus5_wb", wb_en, 1);
    check("plus5_ptr_wb", ptr_wb, 0);
    nxt();
    check("nop_wb", wb_en, 0);
    check("nop_val", val_out, 0);
    present(16'h1000);
    nxt(); ins_valid = 1'b0;
    check("plus_imm0", val_out, 16'h0004);

    // Forwarding on back-to-back same-cell writes with stale memory
    nxt(); val_in = 16'h0000; present(16'h1001);
    nxt();
    check("fwd_first", val_out, 16'h0001);
    nxt(); ins_valid = 1'b0;
    check("fwd_second", val_out, 16'h0002);
    check("fwd_second_wb", wb_en, 1);
    nxt(); present(16'h1001);
    nxt(); present(16'h3001);
    check("nofwd_first", val_out, 16'h0001);
    nxt(); present(16'h1001);
    check("inc_ptr_select", ptr_select, 16'h0001);
    check("inc_wb", wb_en, 0);
    nxt(); ins_valid = 1'b0;
    check("nofwd_second", val_out, 16'h0001);
    check("nofwd_ptr_wb", ptr_wb, 16'h0001);

    // Pointer and value wraparound, unused opcode
    do_reset();
    present(16'h4001);
    nxt(); present(16'h2001);
    check("dec_wrap", ptr_select, 16'hFFFF);
    check("dec_ptr_wb", ptr_wb, 0);
    nxt(); ins_valid = 1'b0;
    check("minus_wrap", val_out, 16'hFFFF);
    check("minus_ptr_wb", ptr_wb, 16'hFFFF);
    nxt(); present(16'h9005);
    nxt(); ins_valid = 1'b0;
    check("op9_wb", wb_en, 0);
    check("op9_ptr", ptr_select, 16'hFFFF);

    // Branches
    do_reset();
    present(16'h5123); val_in = 16'h0000;
    nxt(); present(16'h3001);
    check("brz_taken", branch_en, 1);
    check("brz_target", branch_val, 12'h123);
    check("brz_bubble", ins_ready, 0);
    nxt(); present(16'h5123); val_in = 16'h0007;
    check("brz_dropped", ptr_select, 0);
    check("brz_pulse", branch_en, 0);
    nxt(); present(16'h6123);
    check("brz_not", branch_en, 0);
    check("brz_not_val", branch_val, 0);
    check("brz_no_bubble", ins_ready, 1);
    nxt(); present(16'h6123);
    check("brnz_taken", branch_en, 1);
    check("brnz_target", branch_val, 12'h123);
    nxt(); val_in = 16'h0000;
    nxt(); ins_valid = 1'b0;
    check("brnz_not", branch_en, 0);

    // OUT stall then completion
    do_reset();
    present(16'h7000); val_in = 16'h00AB; out_ready = 1'b0;
    nxt(); ins_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("out_stall_valid", out_valid, 1);
      check("out_stall_data", out_data, 16'h00AB);
      check("out_stall_ready", ins_ready, 0);
      nxt();
    end
    out_ready = 1'b1;
    #1;
    check("out_done_valid", out_valid, 1);
    check("out_done_ready", ins_ready, 1);
    present(16'h8000); in_valid = 1'b0;
    nxt(); ins_valid = 1'b0; out_ready = 1'b0;
    check("out_cleared", out_valid, 0);

    // IN stall then completion
    for (int i = 0; i < 2; i++) begin
      check("in_stall_ready", in_ready, 1);
      check("in_stall_wb", wb_en, 0);
      check("in_stall_ins", ins_ready, 0);
      nxt();
    end
    in_valid = 1'b1; in_data = 16'h0041;
    #1;
    check("in_wb", wb_en, 1);
    check("in_val", val_out, 16'h0041);
    nxt(); in_valid = 1'b0;
    check("in_cleared", in_ready, 0);

    // HALT is sticky
    present(16'hF000);
    nxt(); present(16'h3001);
    for (int i = 0; i < 12; i++) begin
      nxt();
      check("halt_flag", halted, 1);
      check("halt_ins_ready", ins_ready, 0);
    end
    check("halt_ptr", ptr_select, 0);
    ins_valid = 1'b0;

    // Asynchronous reset in the middle of an OUT stall
    do_reset();
    present(16'h3003);
    nxt(); present(16'h7000); out_ready = 1'b0; val_in = 16'h0055;
    check("pre_inc", ptr_select, 16'h0003);
    nxt(); ins_valid = 1'b0;
    check("pre_out_valid", out_valid, 1);
    check("pre_ptr_wb", ptr_wb, 16'h0003);
    nxt();
    #1 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_ptr_wb", ptr_wb, 0);
    check("async_ptr_select", ptr_select, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", ins_ready, 1);
    check("post_rst_out", out_valid, 0);
    nxt();
    check("post_rst_held_out", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bf_alu_pipe.md
# bf_alu_pipe

Parametrised execute unit for the threadbrain core: a successor to the single-step tape ALU. It sits between the instruction fetcher and the tape memory. It executes tape-cell arithmetic, pointer moves and conditional branches with run-length immediates. It adds forwarding, byte I/O handshakes, a HALT state and a valid/ready instruction interface.

## Interface
- DATA_W, 16, tape cell width
- PTR_W, 16, tape pointer width
- ADDR_W, 12, branch target width (must be ≤ 12)

One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ins_in  in  16  instruction: [15:12] opcode, [11:0] operand
- ins_valid  in  1  ins_in valid
- ins_ready  out  1  unit accepts ins_in this cycle
- val_in  in  DATA_W  tape read data; equals mem[ptr_select of previous cycle]
- ptr_select  out  PTR_W  next tape pointer; the read address
- val_out  out  DATA_W  writeback data
- wb_en  out  1  write val_out to mem[ptr_wb] at this clock edge
- ptr_wb  out  PTR_W  current tape pointer
- branch_val  out  ADDR_W  branch target
- branch_en  out  1  branch taken, one-cycle pulse
- out_data  out  DATA_W  output byte/cell
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- in_data  in  DATA_W  input cell
- in_valid  in  1  in_data valid
- in_ready  out  1  unit consumes in_data
- halted  out  1  HALT executed

## Operation
- Execute slot (E) registers: ins, ptr, plus fwd_val and fwd_vld.
- A handshake (ins_valid & ins_ready) loads ins_in into E; otherwise E loads NOP.
- Operand value opv = (fwd_vld && ptr_wb == previous-cycle write pointer) ? fwd_val : val_in.
  - This covers back-to-back writes to the same cell before memory returns fresh data.
- imm = operand[11:0] zero-extended; imm==0 is treated as 1.
- Opcodes:
  - 0 NOP: no effect.
  - 1 PLUS: val_out = opv + imm mod 2^DATA_W; wb_en=1.
  - 2 MINUS: val_out = opv − imm mod 2^DATA_W; wb_en=1.
  - 3 INC: ptr_next = ptr + imm mod 2^PTR_W.
  - 4 DEC: ptr_next = ptr − imm mod 2^PTR_W.
  - 5 BRZ: if opv==0, branch_en=1 and branch_val=operand[ADDR_W−1:0].
  - 6 BRNZ: same as BRZ, but taken when opv≠0.
  - 7 OUT: out_data=opv; out_valid=1 until out_ready.
  - 8 IN: in_ready=1; when in_valid, val_out=in_data and wb_en=1.
  - F HALT: halted=1.
  - 9–E: treated as NOP.
- ptr_select = ptr_next. It equals ptr except on INC/DEC.
- Outputs not asserted by the current opcode are driven 0.

## Timing
- Reset (async, rst_n=0): ptr=0, E=NOP, fwd_vld=0, halted=0.
  - Outputs: wb_en=0, branch_en=0, out_valid=0, in_ready=0, ins_ready=1, ptr_select=0, ptr_wb=0, val_out=0, branch_val=0, out_data=0.
- Latency: an instruction accepted at edge t executes in cycle t+1. wb_en, branch_en and the ptr update complete at edge t+1.
- Throughput: one instruction per cycle with no stalls.
- Stall, OUT: while out_valid && !out_ready:
  - E holds; ins_ready=0; out_data is stable.
  - Completes in the cycle out_ready=1.
- Stall, IN: while !in_valid:
  - E holds; ins_ready=0; wb_en=0.
  - Completes in the cycle in_valid=1.
- During a stall, ptr_select stays equal to ptr. Memory keeps re-reading the same cell, and opv stays valid.
- Branch taken: ins_ready=0 in the branch_en cycle, so no instruction is accepted. The fetcher presents the target from the next cycle.
- Branch not taken: no bubble.
- Forwarding: when wb_en is set at edge t, fwd_val=val_out and fwd_vld=1 for cycle t+1 only.
  - A pointer move in between clears the match (ptr_wb compare).
- HALT: from the next edge, halted=1 and ins_ready=0 permanently; E=NOP. Only reset leaves this state.
- Reset asserted mid-stall or mid-branch: all state clears immediately; a pending OUT/IN is dropped.

## Test plan
- Reset with DATA_W=16, then PLUS imm 5 with val_in=0x0003 -> val_out=0x0008, wb_en=1, ptr_wb=0 one cycle after acceptance.
- Back-to-back PLUS 1, PLUS 1 on the same cell with memory returning a stale 0x0000 -> second val_out=0x0002 via forwarding. With INC 1 inserted between them, there is no forward.
- DEC 1 from ptr=0 -> ptr_select=0xFFFF. MINUS 1 on cell 0x0000 -> val_out=0xFFFF.
- BRZ 0x123 with opv=0 -> branch_en=1, branch_val=0x123, ins_ready=0 that cycle. With opv=7 there is no branch and no bubble. BRNZ inverts this.
- OUT with out_ready low for 3 cycles -> out_valid stays high and out_data stays stable, ins_ready=0 for 3 cycles, then completes. IN with in_valid low 2 cycles then in_data=0x0041 -> wb_en=1, val_out=0x0041.
- HALT -> halted=1, ins_ready=0 held for ≥10 cycles. rst_n pulsed low mid-OUT-stall -> out_valid=0 asynchronously, ptr=0, ins_ready=1 after release.
